// File: rtl/score_bcd_keeper.sv
// Score keeper for the 4-digit display: digit-serial BCD accumulation of
// line-clear points, with a game-over blink between the score and "OVER".
module score_bcd_keeper #(
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_valid,
   input  logic [2:0] clr_lines,
   output logic       clr_ready,
   input  logic       game_over,
   input  logic       new_game,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic [3:0] score_3,
   output logic [3:0] score_4
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {IDLE, ADD} state_t;

   state_t          state_q;
   logic [3:0][3:0] score_q;   // committed score, [3] = thousands
   logic [3:0][3:0] work_q;
   logic [3:0]      inc_q;
   logic            carry_q;
   logic [1:0]      idx_q;
   logic            go_q;
   logic            show_q;
   logic [CW-1:0]   cnt_q;

   logic [4:0]      sum_d;
   logic [3:0]      dig_d;
   logic            cout_d;
   logic [3:0][3:0] work_d;
   logic            legal;
   logic [3:0]      pts;

   assign clr_ready = (state_q == IDLE) && !game_over;
   assign legal     = (clr_lines >= 3'd1) && (clr_lines <= 3'd4);

   always_comb begin
      pts = 4'd0;
      case (clr_lines)
         3'd1:    pts = 4'd1;
         3'd2:    pts = 4'd3;
         3'd3:    pts = 4'd5;
         3'd4:    pts = 4'd8;
         default: pts = 4'd0;
      endcase
   end

   // One BCD digit of the running sum; the increment only enters at digit 0.
   always_comb begin
      sum_d  = {1'b0, work_q[idx_q]} + {1'b0, (idx_q == 2'd0) ? inc_q : 4'd0}
               + {4'd0, carry_q};
      dig_d  = sum_d[3:0];
      cout_d = 1'b0;
      if (sum_d > 5'd9) begin
         dig_d  = 4'(sum_d - 5'd10);
         cout_d = 1'b1;
      end
      work_d        = work_q;
      work_d[idx_q] = dig_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         score_q <= '0;
         work_q  <= '0;
         inc_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (new_game) begin
         state_q <= IDLE;
         score_q <= '0;
         work_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_valid && clr_ready && legal) begin
                  work_q  <= score_q;
                  inc_q   <= pts;
                  carry_q <= 1'b0;
                  idx_q   <= '0;
                  state_q <= ADD;
               end
            end
            ADD: begin
               work_q  <= work_d;
               carry_q <= cout_d;
               idx_q   <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_q <= IDLE;
                  // carry out of the thousands digit pins the score at 9999
                  score_q <= cout_d ? {4{4'd9}} : work_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_q   <= 1'b0;
         show_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         go_q <= game_over;
         if (new_game) begin
            show_q <= 1'b0;
            cnt_q  <= '0;
         end else if (game_over && !go_q) begin
            show_q <= 1'b1;
            cnt_q  <= '0;
         end else if (game_over) begin
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
               show_q <= !show_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            show_q <= 1'b0;
            cnt_q  <= '0;
         end
      end
   end

   assign {score_4, score_3, score_2, score_1} =
      show_q ? {4'd12, 4'd13, 4'd14, 4'd15} : score_q;

endmodule

// File: tb/tb_score_bcd_keeper.sv
// Directed bench for score_bcd_keeper: vector table plus hand-written
// sequences for carry ripple, saturation, abort and the game-over blink.
module tb_score_bcd_keeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clr_valid = 1'b0;
   logic [2:0] clr_lines = 3'd0;
   logic       clr_ready;
   logic       game_over = 1'b0;
   logic       new_game = 1'b0;
   logic [3:0] score_1, score_2, score_3, score_4;

   int nvec = 0;
   int nerr = 0;
   int model = 0;

   score_bcd_keeper #(.BLINK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr_valid(clr_valid), .clr_lines(clr_lines),
      .clr_ready(clr_ready), .game_over(game_over), .new_game(new_game),
      .score_1(score_1), .score_2(score_2), .score_3(score_3), .score_4(score_4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  lines;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [15:0] disp();
      return {score_4, score_3, score_2, score_1};
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int points(input logic [2:0] l);
      case (l)
         3'd1: return 1;
         3'd2: return 3;
         3'd3: return 5;
         3'd4: return 8;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one event from IDLE (called #1 after an edge) and check the
   // busy window, that no partial sum is shown, and the committed result.
   task automatic ev(input logic [2:0] l, input logic [15:0] exp, input string nm);
      logic [15:0] old;
      old = disp();
      chk({nm, "/rdy_in"}, {15'd0, clr_ready}, 16'd1);
      clr_valid = 1'b1;
      clr_lines = l;
      tick();
      clr_valid = 1'b0;
      clr_lines = 3'd0;
      if (l >= 3'd1 && l <= 3'd4) begin
         for (int k = 0; k < 4; k++) begin
            chk({nm, "/busy"}, {15'd0, clr_ready}, 16'd0);
            chk({nm, "/hold"}, disp(), old);
            tick();
         end
         chk({nm, "/rdy_out"}, {15'd0, clr_ready}, 16'd1);
      end else begin
         for (int k = 0; k < 4; k++) begin
            chk({nm, "/ill_rdy"}, {15'd0, clr_ready}, 16'd1);
            chk({nm, "/ill_hold"}, disp(), old);
            tick();
         end
      end
      chk(nm, disp(), exp);
   endtask

   task automatic model_ev(input logic [2:0] l, input string nm);
      model = model + points(l);
      if (model > 9999) model = 9999;
      ev(l, to_bcd(model), nm);
   endtask

   task automatic fill_to(input int target);
      int diff;
      while (model < target) begin
         diff = target - model;
         if (diff >= 8)      model_ev(3'd4, "fill4");
         else if (diff >= 5) model_ev(3'd3, "fill3");
         else if (diff >= 3) model_ev(3'd2, "fill2");
         else                model_ev(3'd1, "fill1");
      end
   endtask

   initial begin
      tbl[0] = '{3'd4, 16'h0008};
      tbl[1] = '{3'd1, 16'h0009};
      tbl[2] = '{3'd2, 16'h0012};
      tbl[3] = '{3'd3, 16'h0017};
      tbl[4] = '{3'd0, 16'h0017};
      tbl[5] = '{3'd6, 16'h0017};
      tbl[6] = '{3'd7, 16'h0017};
      tbl[7] = '{3'd4, 16'h0025};

      // reset asserted mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("rst_disp", disp(), 16'h0000);
      chk("rst_rdy", {15'd0, clr_ready}, 16'd1);
      tick();
      tick();
      chk("rst_disp_hold", disp(), 16'h0000);
      rst_n = 1'b1;
      tick();
      chk("post_rst", disp(), 16'h0000);

      for (int i = 0; i < 8; i++) begin
         ev(tbl[i].lines, tbl[i].exp, $sformatf("tbl%0d", i));
         tick();
      end
      model = 25;

      // carry ripple through three digits
      fill_to(999);
      chk("pre_ripple", disp(), 16'h0999);
      ev(3'd1, 16'h1000, "ripple");
      model = 1000;

      // saturation
      fill_to(9995);
      chk("pre_sat", disp(), 16'h9995);
      ev(3'd4, 16'h9999, "sat4");
      ev(3'd2, 16'h9999, "sat2");

      // new_game two edges into an ADD, with a competing event
      clr_valid = 1'b1;
      clr_lines = 3'd1;
      tick();
      clr_valid = 1'b0;
      tick();
      new_game  = 1'b1;
      clr_valid = 1'b1;
      clr_lines = 3'd4;
      tick();
      new_game  = 1'b0;
      clr_valid = 1'b0;
      chk("abort_disp", disp(), 16'h0000);
      chk("abort_idle", {15'd0, clr_ready}, 16'd1);
      for (int k = 0; k < 6; k++) tick();
      chk("abort_dropped", disp(), 16'h0000);
      chk("abort_rdy", {15'd0, clr_ready}, 16'd1);
      model = 0;

      // build 0123 then blink
      fill_to(123);
      chk("pre_go", disp(), 16'h0123);
      game_over = 1'b1;
      clr_valid = 1'b1;
      clr_lines = 3'd1;
      #1;
      chk("go_rdy_now", {15'd0, clr_ready}, 16'd0);
      chk("go_not_yet", disp(), 16'h0123);
      for (int k = 0; k < 16; k++) begin
         tick();
         chk($sformatf("blink%0d", k), disp(),
             ((k / 4) % 2 == 0) ? 16'hCDEF : 16'h0123);
         chk($sformatf("blink_rdy%0d", k), {15'd0, clr_ready}, 16'd0);
      end
      game_over = 1'b0;
      clr_valid = 1'b0;
      tick();
      chk("go_leave", disp(), 16'h0123);
      chk("go_leave_rdy", {15'd0, clr_ready}, 16'd1);
      for (int k = 0; k < 5; k++) tick();
      chk("go_no_event", disp(), 16'h0123);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/score_bcd_keeper.md
# score_bcd_keeper

Upstream feeder for the 4-digit seven-segment scan driver. Accepts line-clear events from the game logic, accumulates the player's score as four BCD digits with a digit-serial BCD adder, and drives the four 4-bit digit codes the display stage consumes. While the game-over level is high, the digit outputs alternate between the score and the glyph codes spelling "OVER".

## Interface
- BLINK_DIV, 50_000_000: clock cycles per game-over display phase (score/OVER). Legal range is ≥ 2.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clr_valid  in  1  line-clear event request. Accepted on an edge where clr_valid && clr_ready.
- clr_lines  in  3  rows cleared with the event. Legal values are 1..4. Values 0 and 5..7 are accepted and then discarded with no score change.
- clr_ready  out  1  equals (state == IDLE) && !game_over.
- game_over  in  1  level input from the game FSM.
- new_game  in  1  single-cycle synchronous clear pulse.
- score_1  out  4  ones digit, or R (15) during the OVER phase.
- score_2  out  4  tens digit, or E (14) during the OVER phase.
- score_3  out  4  hundreds digit, or V (13) during the OVER phase.
- score_4  out  4  thousands digit, or O (12) during the OVER phase.

## Operation
- **Points table.** The increment is a single BCD digit.
  - 1 line → 1
  - 2 lines → 3
  - 3 lines → 5
  - 4 lines → 8
- **FSM states.** IDLE and ADD.
- **IDLE.** On accept, the block performs all of the following:
  - copies the committed score into the working register
  - loads the increment
  - clears carry and idx
  - moves to ADD
  - If clr_lines is illegal, it stays in IDLE and no state changes.
- **ADD.** One digit per cycle, idx 0→3:
  - t = work[idx] + (idx==0 ? inc : 0) + carry, computed 5 bits wide
  - if t > 9: work[idx] ← t−10 and carry ← 1; otherwise work[idx] ← t and carry ← 0
  - On idx==3, commit the result to the score register and return to IDLE.
- **Saturation.** If digit 3 produces a carry, the committed score is 9,9,9,9, and it stays there on further events.
- **No partial sums visible.** The display outputs only ever show committed scores.
- **Output mux.** Outputs are a 2:1 mux, and both inputs are registered:
  - show_over = 1 selects {O,V,E,R} = {12,13,14,15} on {score_4..score_1}
  - show_over = 0 selects the committed score
- **Blink.** game_over is registered as go_q.
  - Rising edge (game_over && !go_q): show_over ← 1, blink counter ← 0.
  - While game_over is high: the counter counts 0..BLINK_DIV−1. At terminal count, show_over toggles and the counter returns to 0.
  - While game_over is low: show_over ← 0 and counter ← 0.
- **game_over rising during ADD.** The addition completes and commits. No new event is accepted until game_over falls.
- **new_game.** Highest priority. It synchronously performs all of the following:
  - clears the score and the working register
  - forces the FSM to IDLE, aborting any addition in progress
  - clears the blink counter and show_over
  - Any clr_valid on the same edge is dropped.
- **Reset.** Asynchronous reset applies the same clear as new_game, plus go_q ← 0.
  - Output reset values: score_1..score_4 = 0, so the display reads 0000.
  - clr_ready = !game_over.

## Timing
- **Accept to visible.** With an accept at edge N, digits are processed at edges N+1..N+4, and the new score is visible on the outputs after edge N+4. Latency is 4 cycles.
- **Throughput.** clr_ready is low after edge N through edge N+4 and high again from edge N+4. This gives at most one event per 5 cycles.
- **Holding events.** clr_valid must be held until accepted. Events are never queued.
- **OVER onset.** The OVER glyphs appear the cycle after the first edge that samples game_over high.
- **Phase length.** Each subsequent phase lasts exactly BLINK_DIV cycles.
- **Leaving game over.** Outputs return to the score the cycle after game_over is sampled low.

## Test plan
- **Reset and four-line event.** Assert rst_n=0 mid-cycle, release, then issue clr_lines=4 at edge N. Required: outputs read 0000 during reset; clr_ready is low for edges N+1..N+4; outputs read 0008 after N+4.
- **Carry ripple.** Preload 0999 with a sequence of events, then apply clr_lines=1. Required: 1000, with no intermediate value on the outputs.
- **Saturation.** From 9995, apply clr_lines=4 → 9999, then clr_lines=2 → 9999.
- **Illegal input.** Apply clr_lines=0, then clr_lines=6. Required: score unchanged and clr_ready never drops.
- **Game over with BLINK_DIV=4.** Score 0123, raise game_over. Required:
  - outputs {12,13,14,15} for 4 cycles, then 0123 for 4 cycles, repeating
  - clr_ready=0, and clr_valid has no effect
  - outputs return to 0123 after game_over falls
- **new_game abort.** Pulse new_game at edge N+2 of an ADD, together with a new clr_valid. Required: 0000 after N+2, FSM in IDLE, event dropped.
